sprite_scheduler: RTL and testbench
===================================

// Module: sprite_scheduler
// PURPOSE
//  Owns position/visibility of NUM_SPRITES sprite slots feeding the per-sprite buffer renderers.
//  Game logic posts updates via req/ack at any time; updates land in shadow regs, commit to live regs in vblank (no tearing).
//  Pulses BUF_RESET at frame start so renderer X/Y counters realign.
//  Merges renderer pixel outputs by fixed priority (slot 0 on top) into one registered RGB pixel for VGA.
// PARAMETERS
//  NUM_SPRITES  4    number of sprite slots (1..8)
//  ID_W         2    width of UPD_ID, = clog2(NUM_SPRITES), min 1
//  H_ACTIVE     640  visible pixels per line
//  V_ACTIVE     480  visible lines per frame
// PORTS
//  CLK        in   1              pixel clock
//  reset      in   1              asynchronous, active-low
//  X_VGA      in   10             pixel column, already offset to active area
//  Y_VGA      in   10             pixel line, already offset to active area
//  UPD_REQ    in   1              update request; held with data until UPD_ACK
//  UPD_ID     in   ID_W           slot being updated
//  UPD_X      in   10             new top-left X
//  UPD_Y      in   10             new top-left Y
//  UPD_VIS    in   1              new visibility
//  UPD_ACK    out  1              one-cycle accept strobe
//  SPR_X      out  10*NUM_SPRITES live X, slot i at [10*i+:10]
//  SPR_Y      out  10*NUM_SPRITES live Y, same packing
//  SPR_EN     out  NUM_SPRITES    live visibility
//  BUF_RESET  out  1              one-cycle pulse at frame start, to renderer reset
//  HIT_R/G/B  in   NUM_SPRITES    per-slot renderer pixel bit (renderer drives 0 outside its box)
//  HIT        in   NUM_SPRITES    per-slot "pixel inside sprite box"
//  PIX_R/G/B  out  1              merged pixel
// BEHAVIOUR
//  Reset: state=S_DISPLAY, all outputs 0, shadow regs 0, dirty bits 0.
//  FSM: S_DISPLAY -> S_COMMIT on Y_VGA==V_ACTIVE; S_COMMIT -> S_BLANK after NUM_SPRITES cycles;
//   S_BLANK -> S_DISPLAY on Y_VGA==0 && X_VGA==0, same cycle BUF_RESET=1 (registered, visible next edge).
//  Handshake (S_DISPLAY, S_BLANK only): UPD_REQ sampled high and ACK low -> shadow[UPD_ID] written,
//   dirty[UPD_ID]=1, UPD_ACK=1 next cycle for exactly one cycle; ACK never on consecutive cycles.
//  Same slot rewritten before commit: last write wins. UPD_ID >= NUM_SPRITES: acked, discarded.
//  S_COMMIT: cycle k copies shadow[k] to live if dirty[k], clears dirty[k]; UPD_ACK held 0, REQ stalls.
//  REQ arriving in the cycle entering S_COMMIT is not acked; accepted in S_BLANK, committed next frame.
//  Commit clamp: UPD_X>=H_ACTIVE or UPD_Y>=V_ACTIVE -> SPR_EN[k]=0 (X/Y still copied).
//  Pixel merge, latency 1: PIX = HIT_R/G/B of lowest i with HIT[i]&SPR_EN[i]; none -> 0;
//   X_VGA>=H_ACTIVE or Y_VGA>=V_ACTIVE -> 0.
//  Y_VGA jump (missed V_ACTIVE) still leaves S_DISPLAY on Y_VGA>=V_ACTIVE.
//  Reset mid-commit: everything returns to reset values; pending shadow data lost.
// CONFIGURATION
//  SPRITE_SCHED_COLLISION_EN defined: adds output COLLISION [NUM_SPRITES-1:0]; during S_DISPLAY
//   bit i sets when HIT[i]&SPR_EN[i] and any other visible slot hits same pixel; accumulated
//   bits copy to COLLISION on S_COMMIT entry, accumulator then clears. Reset value 0.
//  Undefined: no COLLISION port, no accumulator logic.
// STRUCTURE
//  sprite_sched_pkg: state encoding (S_DISPLAY, S_COMMIT, S_BLANK), COORD_W=10, slot-field widths.
//  Sub-module sprite_priority_mux: registered priority encoder/merge (and collision detect when enabled).
//  Top: FSM, shadow/dirty regs, commit counter, handshake.
// TESTING
//  Reset then free-run frame: SPR_EN=0, PIX=0, one BUF_RESET per frame at (0,0).
//  REQ id=1 X=100 Y=50 VIS=1 at Y=10 -> ACK 1 cycle later; SPR_X[19:10]=100 only after Y reaches 480.
//  Two writes to id=2 (X=10 then X=20) in one frame -> commit shows X=20; no intermediate.
//  REQ held from Y=479 through commit -> no ACK during the 4 commit cycles; ACK in S_BLANK, live next frame.
//  Slots 0,3 visible, HIT=4'b1001, HIT_R=4'b1000 -> PIX_R=0 one cycle later (slot 0 wins).
//  UPD_X=700 VIS=1 -> SPR_EN bit 0 after commit; COLLISION_EN: overlap 0/1 -> COLLISION=2'b11 at next commit.

Source files
------------

// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite scheduler: state encoding, coordinate width
// and the per-slot shadow/live record.
package sprite_sched_pkg;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned CNT_W   = 3;
   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] S_DISPLAY = 2'd0;
   localparam logic [STATE_W-1:0] S_COMMIT  = 2'd1;
   localparam logic [STATE_W-1:0] S_BLANK   = 2'd2;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               vis;
   } slot_t;

endpackage

// File: rtl/sprite_priority_mux.sv
// Registered fixed-priority merge of renderer pixels (slot 0 on top).
// With SPRITE_SCHED_COLLISION_EN, also reports per-slot overlap of visible hits (combinational).
module sprite_priority_mux
   import sprite_sched_pkg::*;
#(
   parameter int unsigned NUM_SPRITES = 4,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [COORD_W-1:0]     x_vga,
   input  logic [COORD_W-1:0]     y_vga,
   input  logic [NUM_SPRITES-1:0] hit,
   input  logic [NUM_SPRITES-1:0] hit_r,
   input  logic [NUM_SPRITES-1:0] hit_g,
   input  logic [NUM_SPRITES-1:0] hit_b,
   input  logic [NUM_SPRITES-1:0] spr_en,
`ifdef SPRITE_SCHED_COLLISION_EN
   output logic [NUM_SPRITES-1:0] coll_hit,
`endif
   output logic                   pix_r,
   output logic                   pix_g,
   output logic                   pix_b
);

   localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);

   logic [2:0] pix_d, pix_q;
   logic       found;

   always_comb begin
      pix_d = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
         if (!found && hit[i] && spr_en[i]) begin
            pix_d = {hit_r[i], hit_g[i], hit_b[i]};
            found = 1'b1;
         end
      end
      if (x_vga >= H_LIM || y_vga >= V_LIM) begin
         pix_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q <= '0;
      end else begin
         pix_q <= pix_d;
      end
   end

   assign pix_r = pix_q[2];
   assign pix_g = pix_q[1];
   assign pix_b = pix_q[0];

`ifdef SPRITE_SCHED_COLLISION_EN
   logic [NUM_SPRITES-1:0] active;
   logic [NUM_SPRITES-1:0] others;

   always_comb begin
      active   = hit & spr_en;
      coll_hit = '0;
      others   = '0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
         others      = active;
         others[i]   = 1'b0;
         coll_hit[i] = active[i] && (|others);
      end
   end
`endif

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite slot scheduler: shadow/live position registers committed in vblank, frame-start
// renderer reset pulse, merged pixel output. Optional macro: SPRITE_SCHED_COLLISION_EN.
module sprite_scheduler
   import sprite_sched_pkg::*;
#(
   parameter int unsigned NUM_SPRITES = 4,
   parameter int unsigned ID_W        = 2,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480
) (
   input  logic                           CLK,
   input  logic                           reset,
   input  logic [COORD_W-1:0]             X_VGA,
   input  logic [COORD_W-1:0]             Y_VGA,
   input  logic                           UPD_REQ,
   input  logic [ID_W-1:0]                UPD_ID,
   input  logic [COORD_W-1:0]             UPD_X,
   input  logic [COORD_W-1:0]             UPD_Y,
   input  logic                           UPD_VIS,
   output logic                           UPD_ACK,
   output logic [COORD_W*NUM_SPRITES-1:0] SPR_X,
   output logic [COORD_W*NUM_SPRITES-1:0] SPR_Y,
   output logic [NUM_SPRITES-1:0]         SPR_EN,
   output logic                           BUF_RESET,
   input  logic [NUM_SPRITES-1:0]         HIT_R,
   input  logic [NUM_SPRITES-1:0]         HIT_G,
   input  logic [NUM_SPRITES-1:0]         HIT_B,
   input  logic [NUM_SPRITES-1:0]         HIT,
`ifdef SPRITE_SCHED_COLLISION_EN
   output logic [NUM_SPRITES-1:0]         COLLISION,
`endif
   output logic                           PIX_R,
   output logic                           PIX_G,
   output logic                           PIX_B
);

   localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);

   logic [STATE_W-1:0]     state_d, state_q;
   logic [CNT_W-1:0]       cnt_d, cnt_q;
   logic                   ack_d, ack_q;
   logic                   buf_reset_d, buf_reset_q;
   logic [NUM_SPRITES-1:0] dirty_d, dirty_q;
   slot_t                  shadow_d [NUM_SPRITES];
   slot_t                  shadow_q [NUM_SPRITES];
   slot_t                  live_d   [NUM_SPRITES];
   slot_t                  live_q   [NUM_SPRITES];
   logic                   leaving_display;
   logic                   accept;

   // Leaving on >= rather than == so a frame whose Y skips V_ACTIVE still commits.
   assign leaving_display = (state_q == S_DISPLAY) && (Y_VGA >= V_LIM);
   assign accept = UPD_REQ && !ack_q &&
                   ((state_q == S_BLANK) || ((state_q == S_DISPLAY) && !leaving_display));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dirty_d     = dirty_q;
      shadow_d    = shadow_q;
      live_d      = live_q;
      ack_d       = 1'b0;
      buf_reset_d = 1'b0;

      case (state_q)
         S_DISPLAY: begin
            if (leaving_display) begin
               state_d = S_COMMIT;
               cnt_d   = '0;
            end
         end
         S_COMMIT: begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
               if (32'(cnt_q) == i && dirty_q[i]) begin
                  live_d[i].x   = shadow_q[i].x;
                  live_d[i].y   = shadow_q[i].y;
                  live_d[i].vis = shadow_q[i].vis &&
                                  (shadow_q[i].x < H_LIM) && (shadow_q[i].y < V_LIM);
                  dirty_d[i]    = 1'b0;
               end
            end
            if (32'(cnt_q) == NUM_SPRITES - 1) begin
               state_d = S_BLANK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BLANK: begin
            if (X_VGA == '0 && Y_VGA == '0) begin
               state_d     = S_DISPLAY;
               buf_reset_d = 1'b1;
            end
         end
         default: state_d = S_DISPLAY;
      endcase

      // Out-of-range ids match no slot: the request is acknowledged and dropped.
      if (accept) begin
         ack_d = 1'b1;
         for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (32'(UPD_ID) == i) begin
               shadow_d[i] = '{x: UPD_X, y: UPD_Y, vis: UPD_VIS};
               dirty_d[i]  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q     <= S_DISPLAY;
         cnt_q       <= '0;
         ack_q       <= 1'b0;
         buf_reset_q <= 1'b0;
         dirty_q     <= '0;
         for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            shadow_q[i] <= '0;
            live_q[i]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ack_q       <= ack_d;
         buf_reset_q <= buf_reset_d;
         dirty_q     <= dirty_d;
         shadow_q    <= shadow_d;
         live_q      <= live_d;
      end
   end

   always_comb begin
      SPR_X  = '0;
      SPR_Y  = '0;
      SPR_EN = '0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
         SPR_X[COORD_W*i +: COORD_W] = live_q[i].x;
         SPR_Y[COORD_W*i +: COORD_W] = live_q[i].y;
         SPR_EN[i]                   = live_q[i].vis;
      end
   end

   assign UPD_ACK   = ack_q;
   assign BUF_RESET = buf_reset_q;

`ifdef SPRITE_SCHED_COLLISION_EN
   logic [NUM_SPRITES-1:0] coll_hit;
   logic [NUM_SPRITES-1:0] acc_d, acc_q;
   logic [NUM_SPRITES-1:0] coll_d, coll_q;

   always_comb begin
      acc_d  = acc_q;
      coll_d = coll_q;
      if (state_q == S_DISPLAY) begin
         acc_d = acc_q | coll_hit;
         if (leaving_display) begin
            coll_d = acc_q | coll_hit;
            acc_d  = '0;
         end
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         acc_q  <= '0;
         coll_q <= '0;
      end else begin
         acc_q  <= acc_d;
         coll_q <= coll_d;
      end
   end

   assign COLLISION = coll_q;
`endif

   sprite_priority_mux #(
      .NUM_SPRITES (NUM_SPRITES),
      .H_ACTIVE    (H_ACTIVE),
      .V_ACTIVE    (V_ACTIVE)
   ) u_mux (
      .clk      (CLK),
      .rst_n    (reset),
      .x_vga    (X_VGA),
      .y_vga    (Y_VGA),
      .hit      (HIT),
      .hit_r    (HIT_R),
      .hit_g    (HIT_G),
      .hit_b    (HIT_B),
      .spr_en   (SPR_EN),
`ifdef SPRITE_SCHED_COLLISION_EN
      .coll_hit (coll_hit),
`endif
      .pix_r    (PIX_R),
      .pix_g    (PIX_G),
      .pix_b    (PIX_B)
   );

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler using a compressed raster (X/Y driven directly).
module tb_sprite_scheduler;

   logic        CLK = 1'b0;
   logic        reset;
   logic [9:0]  X_VGA, Y_VGA;
   logic        UPD_REQ;
   logic [1:0]  UPD_ID;
   logic [9:0]  UPD_X, UPD_Y;
   logic        UPD_VIS;
   logic        UPD_ACK;
   logic [39:0] SPR_X, SPR_Y;
   logic [3:0]  SPR_EN;
   logic        BUF_RESET;
   logic [3:0]  HIT_R, HIT_G, HIT_B, HIT;
   logic        PIX_R, PIX_G, PIX_B;
`ifdef SPRITE_SCHED_COLLISION_EN
   logic [3:0]  COLLISION;
`endif

   int tests  = 0;
   int failed = 0;
   int br_cnt = 0;

   always #5 CLK = ~CLK;

   sprite_scheduler #(
      .NUM_SPRITES (4),
      .ID_W        (2),
      .H_ACTIVE    (640),
      .V_ACTIVE    (480)
   ) dut (
      .CLK       (CLK),
      .reset     (reset),
      .X_VGA     (X_VGA),
      .Y_VGA     (Y_VGA),
      .UPD_REQ   (UPD_REQ),
      .UPD_ID    (UPD_ID),
      .UPD_X     (UPD_X),
      .UPD_Y     (UPD_Y),
      .UPD_VIS   (UPD_VIS),
      .UPD_ACK   (UPD_ACK),
      .SPR_X     (SPR_X),
      .SPR_Y     (SPR_Y),
      .SPR_EN    (SPR_EN),
      .BUF_RESET (BUF_RESET),
      .HIT_R     (HIT_R),
      .HIT_G     (HIT_G),
      .HIT_B     (HIT_B),
      .HIT       (HIT),
`ifdef SPRITE_SCHED_COLLISION_EN
      .COLLISION (COLLISION),
`endif
      .PIX_R     (PIX_R),
      .PIX_G     (PIX_G),
      .PIX_B     (PIX_B)
   );

   task automatic tick;
      @(posedge CLK);
      #1;
      if (BUF_RESET === 1'b1) br_cnt++;
   endtask

   task automatic do_write(input logic [1:0] id, input logic [9:0] x, input logic [9:0] y,
                           input logic vis);
      UPD_REQ = 1'b1; UPD_ID = id; UPD_X = x; UPD_Y = y; UPD_VIS = vis;
      tick;
      tests++;
      if (UPD_ACK !== 1'b1) begin
         failed++;
         $display("FAIL write_ack id=%0d: got %b, expected 1", id, UPD_ACK);
      end
      UPD_REQ = 1'b0;
      tick;
      tests++;
      if (UPD_ACK !== 1'b0) begin
         failed++;
         $display("FAIL write_ack_single id=%0d: got %b, expected 0", id, UPD_ACK);
      end
   endtask

   // Drives the vblank row through commit, then (0,0) and one display pixel.
   task automatic commit_frame(input logic [9:0] y_blank);
      X_VGA = 10'd0; Y_VGA = y_blank;
      repeat (5) tick;
      X_VGA = 10'd0; Y_VGA = 10'd0;
      tick;
      Y_VGA = 10'd1;
      tick;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      X_VGA = '0; Y_VGA = '0; UPD_REQ = 1'b0; UPD_ID = '0; UPD_X = '0; UPD_Y = '0;
      UPD_VIS = 1'b0; HIT = '0; HIT_R = '0; HIT_G = '0; HIT_B = '0;
      #3 reset = 1'b0;
      tick; tick;
      tests++;
      if ({SPR_X, SPR_Y, SPR_EN} !== '0) begin
         failed++;
         $display("FAIL reset_live: got %h/%h/%b, expected all 0", SPR_X, SPR_Y, SPR_EN);
      end
      tests++;
      if ({UPD_ACK, BUF_RESET, PIX_R, PIX_G, PIX_B} !== 5'b0) begin
         failed++;
         $display("FAIL reset_ctrl: got %b, expected 00000",
                  {UPD_ACK, BUF_RESET, PIX_R, PIX_G, PIX_B});
      end
      reset = 1'b1;
      tick;
   endtask

   task automatic test_frame;
      logic bad_pix, bad_br;
      bad_pix = 1'b0; bad_br = 1'b0;
      br_cnt = 0;
      HIT = 4'hF; HIT_R = 4'hF; HIT_G = 4'hF; HIT_B = 4'hF;
      for (int y = 0; y < 3; y++) begin
         for (int x = 0; x < 4; x++) begin
            X_VGA = 10'(x); Y_VGA = 10'(y);
            tick;
            if ({PIX_R, PIX_G, PIX_B} !== 3'b000) bad_pix = 1'b1;
            if (BUF_RESET !== 1'b0) bad_br = 1'b1;
         end
      end
      tests++;
      if (bad_pix) begin
         failed++;
         $display("FAIL frame_pix_invisible: got nonzero pixel, expected 0");
      end
      HIT = '0; HIT_R = '0; HIT_G = '0; HIT_B = '0;
      X_VGA = 10'd0; Y_VGA = 10'd480;
      repeat (5) begin
         tick;
         if (BUF_RESET !== 1'b0) bad_br = 1'b1;
      end
      tests++;
      if (bad_br) begin
         failed++;
         $display("FAIL frame_buf_reset_early: got pulse before frame start, expected none");
      end
      Y_VGA = 10'd0;
      tick;
      tests++;
      if (BUF_RESET !== 1'b1) begin
         failed++;
         $display("FAIL frame_buf_reset: got %b, expected 1", BUF_RESET);
      end
      X_VGA = 10'd1;
      tick;
      tests++;
      if (BUF_RESET !== 1'b0 || br_cnt != 1) begin
         failed++;
         $display("FAIL frame_buf_reset_once: got %b cnt=%0d, expected 0 cnt=1", BUF_RESET, br_cnt);
      end
      tests++;
      if (SPR_EN !== 4'b0000) begin
         failed++;
         $display("FAIL frame_spr_en: got %b, expected 0000", SPR_EN);
      end
   endtask

   task automatic test_update;
      X_VGA = 10'd5; Y_VGA = 10'd10;
      do_write(2'd1, 10'd100, 10'd50, 1'b1);
      tests++;
      if (SPR_X[19:10] !== 10'd0) begin
         failed++;
         $display("FAIL update_not_early: got %0d, expected 0", SPR_X[19:10]);
      end
      X_VGA = 10'd0; Y_VGA = 10'd480;
      tick;
      tests++;
      if (SPR_X[19:10] !== 10'd0) begin
         failed++;
         $display("FAIL update_commit_entry: got %0d, expected 0", SPR_X[19:10]);
      end
      repeat (4) tick;
      tests++;
      if (SPR_X[19:10] !== 10'd100 || SPR_Y[19:10] !== 10'd50 || SPR_EN !== 4'b0010) begin
         failed++;
         $display("FAIL update_commit: got x=%0d y=%0d en=%b, expected x=100 y=50 en=0010",
                  SPR_X[19:10], SPR_Y[19:10], SPR_EN);
      end
      Y_VGA = 10'd0; tick;
      Y_VGA = 10'd1; tick;
   endtask

   task automatic test_last_write_wins;
      logic seen10;
      seen10 = 1'b0;
      X_VGA = 10'd3; Y_VGA = 10'd20;
      do_write(2'd2, 10'd10, 10'd7, 1'b0);
      do_write(2'd2, 10'd20, 10'd7, 1'b0);
      X_VGA = 10'd0; Y_VGA = 10'd480;
      repeat (5) begin
         tick;
         if (SPR_X[29:20] === 10'd10) seen10 = 1'b1;
      end
      tests++;
      if (seen10 || SPR_X[29:20] !== 10'd20) begin
         failed++;
         $display("FAIL last_write_wins: got x=%0d seen10=%b, expected x=20 seen10=0",
                  SPR_X[29:20], seen10);
      end
      Y_VGA = 10'd0; tick;
      Y_VGA = 10'd1; tick;
   endtask

   task automatic test_req_during_commit;
      logic acked;
      acked = 1'b0;
      X_VGA = 10'd0; Y_VGA = 10'd480;
      UPD_REQ = 1'b1; UPD_ID = 2'd0; UPD_X = 10'd30; UPD_Y = 10'd40; UPD_VIS = 1'b1;
      repeat (5) begin
         tick;
         if (UPD_ACK !== 1'b0) acked = 1'b1;
      end
      tests++;
      if (acked) begin
         failed++;
         $display("FAIL commit_stall: got ack during entry/commit, expected none");
      end
      tick;
      tests++;
      if (UPD_ACK !== 1'b1) begin
         failed++;
         $display("FAIL blank_ack: got %b, expected 1", UPD_ACK);
      end
      UPD_REQ = 1'b0;
      tests++;
      if (SPR_X[9:0] !== 10'd0) begin
         failed++;
         $display("FAIL blank_not_live: got %0d, expected 0", SPR_X[9:0]);
      end
      Y_VGA = 10'd0; tick;
      Y_VGA = 10'd1; tick;
      commit_frame(10'd480);
      tests++;
      if (SPR_X[9:0] !== 10'd30 || SPR_Y[9:0] !== 10'd40 || SPR_EN !== 4'b0011) begin
         failed++;
         $display("FAIL blank_next_frame: got x=%0d y=%0d en=%b, expected x=30 y=40 en=0011",
                  SPR_X[9:0], SPR_Y[9:0], SPR_EN);
      end
   endtask

   task automatic test_pixel_merge;
      logic [3:0] v_hit [8];
      logic [3:0] v_r   [8];
      logic [3:0] v_g   [8];
      logic [3:0] v_b   [8];
      logic [9:0] v_x   [8];
      logic [9:0] v_y   [8];
      logic [2:0] v_exp [8];
      X_VGA = 10'd50; Y_VGA = 10'd20;
      do_write(2'd3, 10'd200, 10'd100, 1'b1);
      commit_frame(10'd480);
      // Visible slots now 0, 1, 3; slot 2 hidden.
      v_hit[0] = 4'b1001; v_r[0] = 4'b1000; v_g[0] = 4'b0000; v_b[0] = 4'b0001;
      v_x[0] = 10'd50;  v_y[0] = 10'd20;  v_exp[0] = 3'b001;
      v_hit[1] = 4'b1000; v_r[1] = 4'b1000; v_g[1] = 4'b1000; v_b[1] = 4'b0000;
      v_x[1] = 10'd50;  v_y[1] = 10'd20;  v_exp[1] = 3'b110;
      v_hit[2] = 4'b0100; v_r[2] = 4'b0100; v_g[2] = 4'b0100; v_b[2] = 4'b0100;
      v_x[2] = 10'd50;  v_y[2] = 10'd20;  v_exp[2] = 3'b000;
      v_hit[3] = 4'b0110; v_r[3] = 4'b0010; v_g[3] = 4'b0100; v_b[3] = 4'b0000;
      v_x[3] = 10'd50;  v_y[3] = 10'd20;  v_exp[3] = 3'b100;
      v_hit[4] = 4'b0000; v_r[4] = 4'b1111; v_g[4] = 4'b1111; v_b[4] = 4'b1111;
      v_x[4] = 10'd50;  v_y[4] = 10'd20;  v_exp[4] = 3'b000;
      v_hit[5] = 4'b1000; v_r[5] = 4'b1000; v_g[5] = 4'b0000; v_b[5] = 4'b0000;
      v_x[5] = 10'd640; v_y[5] = 10'd20;  v_exp[5] = 3'b000;
      v_hit[6] = 4'b1000; v_r[6] = 4'b1000; v_g[6] = 4'b0000; v_b[6] = 4'b0000;
      v_x[6] = 10'd639; v_y[6] = 10'd479; v_exp[6] = 3'b100;
      v_hit[7] = 4'b1000; v_r[7] = 4'b1000; v_g[7] = 4'b0000; v_b[7] = 4'b0000;
      v_x[7] = 10'd10;  v_y[7] = 10'd480; v_exp[7] = 3'b000;
      for (int i = 0; i < 8; i++) begin
         HIT = v_hit[i]; HIT_R = v_r[i]; HIT_G = v_g[i]; HIT_B = v_b[i];
         X_VGA = v_x[i]; Y_VGA = v_y[i];
         tick;
         tests++;
         if ({PIX_R, PIX_G, PIX_B} !== v_exp[i]) begin
            failed++;
            $display("FAIL pixel_merge[%0d]: got %b, expected %b", i, {PIX_R, PIX_G, PIX_B},
                     v_exp[i]);
         end
      end
      HIT = '0; HIT_R = '0; HIT_G = '0; HIT_B = '0;
      commit_frame(10'd480);
   endtask

   task automatic test_clamp_and_jump;
      X_VGA = 10'd0; Y_VGA = 10'd20;
      do_write(2'd0, 10'd700, 10'd10, 1'b1);
      do_write(2'd3, 10'd639, 10'd479, 1'b1);
      do_write(2'd1, 10'd100, 10'd480, 1'b1);
      commit_frame(10'd500);
      tests++;
      if (SPR_EN !== 4'b1000) begin
         failed++;
         $display("FAIL clamp_en: got %b, expected 1000", SPR_EN);
      end
      tests++;
      if (SPR_X[9:0] !== 10'd700 || SPR_Y[39:30] !== 10'd479 || SPR_Y[19:10] !== 10'd480) begin
         failed++;
         $display("FAIL clamp_coords: got x0=%0d y3=%0d y1=%0d, expected 700 479 480",
                  SPR_X[9:0], SPR_Y[39:30], SPR_Y[19:10]);
      end
   endtask

   task automatic test_reset_mid_commit;
      X_VGA = 10'd0; Y_VGA = 10'd20;
      do_write(2'd2, 10'd33, 10'd44, 1'b1);
      Y_VGA = 10'd480;
      tick; tick;
      reset = 1'b0;
      #2;
      tests++;
      if ({SPR_X, SPR_Y, SPR_EN, UPD_ACK, BUF_RESET} !== '0) begin
         failed++;
         $display("FAIL reset_mid_commit: got x=%h en=%b, expected all 0", SPR_X, SPR_EN);
      end
      tick;
      reset = 1'b1;
      Y_VGA = 10'd1;
      tick;
      commit_frame(10'd480);
      tests++;
      if (SPR_X[29:20] !== 10'd0 || SPR_EN !== 4'b0000) begin
         failed++;
         $display("FAIL reset_shadow_lost: got x2=%0d en=%b, expected 0 0000", SPR_X[29:20], SPR_EN);
      end
   endtask

`ifdef SPRITE_SCHED_COLLISION_EN
   task automatic test_collision;
      X_VGA = 10'd0; Y_VGA = 10'd20;
      do_write(2'd0, 10'd10, 10'd10, 1'b1);
      do_write(2'd1, 10'd12, 10'd12, 1'b1);
      commit_frame(10'd480);
      Y_VGA = 10'd20;
      HIT = 4'b0011; tick;
      HIT = 4'b0000; tick;
      tests++;
      if (COLLISION !== 4'b0000) begin
         failed++;
         $display("FAIL collision_early: got %b, expected 0000", COLLISION);
      end
      commit_frame(10'd480);
      tests++;
      if (COLLISION !== 4'b0011) begin
         failed++;
         $display("FAIL collision: got %b, expected 0011", COLLISION);
      end
      commit_frame(10'd480);
      tests++;
      if (COLLISION !== 4'b0000) begin
         failed++;
         $display("FAIL collision_clear: got %b, expected 0000", COLLISION);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_frame;
      test_update;
      test_last_write_wins;
      test_req_during_commit;
      test_pixel_merge;
      test_clamp_and_jump;
      test_reset_mid_commit;
`ifdef SPRITE_SCHED_COLLISION_EN
      test_collision;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
